// File: rtl/rf_fifo_ctrl.sv
// FIFO controller that sequences an external register file: it owns the
// read/write pointers and occupancy count, drives the register-file strobes
// and addresses, and reports status plus sticky overflow/underflow errors.
module rf_fifo_ctrl #(
    parameter int WS       = 4,
    parameter int DEPTH    = 8,
    parameter int AS       = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [WS-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          wr,
    output logic [AS-1:0] AddrWr,
    output logic [WS-1:0] DataWr,
    output logic          rd,
    output logic [AS-1:0] AddrRd,
    output logic          pop_valid,
    output logic [AS:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AS:0] FULL_C = (AS+1)'(DEPTH);
    localparam logic [AS:0] AF_C   = (AS+1)'(AF_LEVEL);
    localparam logic [AS:0] AE_C   = (AS+1)'(AE_LEVEL);

    logic [AS-1:0] wr_ptr_q, wr_ptr_d;
    logic [AS-1:0] rd_ptr_q, rd_ptr_d;
    logic [AS:0]   count_q, count_d;
    logic          pop_pend_q, pop_pend_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_ok, pop_ok;

    // Accept decisions come from the registered count only, so a push can
    // never use the slot a same-cycle pop frees (and vice versa). Reset and
    // flush suppress all register-file traffic.
    always_comb begin
        push_ok = push && !reset && !flush && (count_q != FULL_C);
        pop_ok  = pop  && !reset && !flush && (count_q != '0);

        wr     = push_ok;
        AddrWr = push_ok ? wr_ptr_q  : '0;
        DataWr = push_ok ? push_data : '0;
        rd     = pop_ok;
        AddrRd = pop_ok ? rd_ptr_q : '0;
    end

    // Next-state logic for pointers, occupancy, pending read and error flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pop_pend_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            // DEPTH is a power of two, so plain increment wraps correctly.
            if (push_ok) wr_ptr_d = wr_ptr_q + AS'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AS'(1);

            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AS+1)'(1);
                2'b01:   count_d = count_q - (AS+1)'(1);
                default: count_d = count_q;
            endcase

            // The register file presents read data one cycle after rd.
            pop_pend_d = pop_ok;
            ovf_d      = ovf_q | (push && !push_ok);
            unf_d      = unf_q | (pop && !pop_ok);
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pop_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pop_pend_q <= pop_pend_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Status outputs derive only from registered state.
    always_comb begin
        pop_valid    = pop_pend_q;
        count        = count_q;
        full         = (count_q == FULL_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        overflow     = ovf_q;
        underflow    = unf_q;
    end

endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Bench for rf_fifo_ctrl: attaches a small register-file model, runs a
// vector table, directed corner sequences and a randomized run, all checked
// against a queue-based FIFO reference model.
module tb_rf_fifo_ctrl;

    localparam int WS    = 4;
    localparam int DEPTH = 8;
    localparam int AS    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic [WS-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic          wr, rd, pop_valid;
    logic [AS-1:0] AddrWr, AddrRd;
    logic [WS-1:0] DataWr;
    logic [AS:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    rf_fifo_ctrl #(.WS(WS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .pop(pop), .flush(flush), .wr(wr), .AddrWr(AddrWr), .DataWr(DataWr),
        .rd(rd), .AddrRd(AddrRd), .pop_valid(pop_valid), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Register file with registered read, as seen by the controller.
    logic [WS-1:0] rf_mem [DEPTH];
    logic [WS-1:0] rf_dout;
    always @(posedge clk) begin
        if (wr) rf_mem[AddrWr] <= DataWr;
        if (rd) rf_dout <= rf_mem[AddrRd];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, addresses from total op counts.
    logic [WS-1:0] mq[$];
    int            m_wtot, m_rtot;
    bit            m_ovf, m_unf, m_pend;
    logic [WS-1:0] m_pdata;

    // Values observed at the most recent mid-cycle sample.
    int obs_wr, obs_aw, obs_rd, obs_ar, obs_cnt, obs_full, obs_empty;
    int obs_af, obs_ae, obs_ovf, obs_unf, obs_pv, obs_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_wtot = 0;
        m_rtot = 0;
        m_ovf  = 0;
        m_unf  = 0;
        m_pend = 0;
    endtask

    // One clock cycle: drive, sample at the falling edge, compare with the
    // model, then advance the model across the rising edge.
    task automatic cycle(input bit p, input logic [WS-1:0] d, input bit q,
                         input bit f, input string tag);
        bit e_push, e_pop;
        int sz;
        push = p; push_data = d; pop = q; flush = f;
        #4;
        sz     = mq.size();
        e_push = p && !f && (sz < DEPTH);
        e_pop  = q && !f && (sz > 0);

        obs_wr = int'(wr); obs_aw = int'(AddrWr); obs_rd = int'(rd); obs_ar = int'(AddrRd);
        obs_cnt = int'(count); obs_full = int'(full); obs_empty = int'(empty);
        obs_af = int'(almost_full); obs_ae = int'(almost_empty);
        obs_ovf = int'(overflow); obs_unf = int'(underflow);
        obs_pv = int'(pop_valid); obs_dout = int'(rf_dout);

        chk("wr", 32'(wr), 32'(e_push));
        chk("AddrWr", 32'(AddrWr), e_push ? 32'(m_wtot % DEPTH) : 32'd0);
        chk("DataWr", 32'(DataWr), e_push ? 32'(d) : 32'd0);
        chk("rd", 32'(rd), 32'(e_pop));
        chk("AddrRd", 32'(AddrRd), e_pop ? 32'(m_rtot % DEPTH) : 32'd0);
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= DEPTH - 1));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("pop_valid", 32'(pop_valid), 32'(m_pend));
        if (m_pend) chk("pop_data", 32'(rf_dout), 32'(m_pdata));

        $display("[%0t] %s push=%0d d=%h pop=%0d flush=%0d wr=%0d aw=%0d rd=%0d ar=%0d cnt=%0d ovf=%0d unf=%0d pv=%0d",
                 $time, tag, p, d, q, f, wr, AddrWr, rd, AddrRd, count, overflow, underflow, pop_valid);

        @(posedge clk);
        #1;
        if (f) begin
            model_clear();
        end else begin
            if (e_push) begin
                mq.push_back(d);
                m_wtot++;
            end
            m_pend = e_pop;
            if (e_pop) begin
                m_pdata = mq.pop_front();
                m_rtot++;
            end
            if (p && !e_push) m_ovf = 1;
            if (q && !e_pop)  m_unf = 1;
        end
    endtask

    // Hold reset for n cycles while requesting traffic; nothing may leak out.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1; push = 1'b1; pop = 1'b1; flush = 1'b0; push_data = 4'hF;
            #4;
            chk("rst_wr", 32'(wr), 32'd0);
            chk("rst_rd", 32'(rd), 32'd0);
            chk("rst_AddrWr", 32'(AddrWr), 32'd0);
            chk("rst_AddrRd", 32'(AddrRd), 32'd0);
            chk("rst_DataWr", 32'(DataWr), 32'd0);
            $display("[%0t] reset cycle %0d", $time, i);
            @(posedge clk);
            #1;
        end
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        model_clear();
    endtask

    typedef struct {
        bit            p;
        logic [WS-1:0] d;
        bit            q;
        bit            f;
        int            wr;
        int            aw;
        int            rd;
        int            ar;
        int            cnt;
        int            ovf;
        int            unf;
        int            pv;
    } vec_t;

    vec_t vt[14];

    initial begin
        //        p  d     q  f  wr aw rd ar cnt ovf unf pv
        vt[0]  = '{1, 4'hA, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 4'h5, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        vt[2]  = '{0, 4'h0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0};
        vt[3]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        vt[4]  = '{1, 4'h3, 1, 0, 1, 2, 1, 1, 1, 0, 0, 0};
        vt[5]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        vt[6]  = '{0, 4'h0, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0};
        vt[7]  = '{0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[8]  = '{1, 4'h9, 1, 0, 1, 3, 0, 0, 0, 0, 1, 0};
        vt[9]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        vt[10] = '{0, 4'h0, 1, 0, 0, 0, 1, 3, 1, 0, 1, 0};
        vt[11] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[12] = '{1, 4'h7, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        vt[13] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        @(posedge clk);
        #1;
        do_reset(2);

        // Vector table: basic push/pop, underflow, simultaneous ops, flush.
        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].p, vt[i].d, vt[i].q, vt[i].f, "tbl");
            chk("tbl_wr", 32'(obs_wr), 32'(vt[i].wr));
            chk("tbl_aw", 32'(obs_aw), 32'(vt[i].aw));
            chk("tbl_rd", 32'(obs_rd), 32'(vt[i].rd));
            chk("tbl_ar", 32'(obs_ar), 32'(vt[i].ar));
            chk("tbl_cnt", 32'(obs_cnt), 32'(vt[i].cnt));
            chk("tbl_ovf", 32'(obs_ovf), 32'(vt[i].ovf));
            chk("tbl_unf", 32'(obs_unf), 32'(vt[i].unf));
            chk("tbl_pv", 32'(obs_pv), 32'(vt[i].pv));
            if (i == 3) chk("tbl_first_pop_data", 32'(obs_dout), 32'hA);
        end

        // Fill to full, overflow, then drain in order.
        cycle(0, 0, 0, 1, "flush");
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 4'(i), 0, 0, "fill");
            chk("fill_aw", 32'(obs_aw), 32'(i));
            chk("fill_af", 32'(obs_af), 32'(i >= DEPTH - 1));
        end
        cycle(1, 4'hE, 0, 0, "push9");
        chk("push9_wr", 32'(obs_wr), 32'd0);
        chk("push9_full", 32'(obs_full), 32'd1);
        cycle(0, 0, 0, 0, "idle");
        chk("ovf_set", 32'(obs_ovf), 32'd1);
        chk("ovf_cnt", 32'(obs_cnt), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 1, 0, "drain");
            chk("drain_ar", 32'(obs_ar), 32'(i));
            if (i > 0) chk("drain_data", 32'(obs_dout), 32'(i - 1));
        end
        cycle(0, 0, 0, 0, "idle");
        chk("drain_last", 32'(obs_dout), 32'(DEPTH - 1));
        chk("drain_empty", 32'(obs_empty), 32'd1);

        // Pointer wrap-around.
        cycle(0, 0, 0, 1, "flush");
        for (int i = 0; i < 6; i++) cycle(1, 4'(i + 3), 0, 0, "wpush");
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, "wpop");
        for (int i = 0; i < 4; i++) begin
            cycle(1, 4'(i + 9), 0, 0, "wrap_push");
            chk("wrap_aw", 32'(obs_aw), 32'((6 + i) % DEPTH));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, "wrap_pop");
            chk("wrap_ar", 32'(obs_ar), 32'((6 + i) % DEPTH));
        end

        // Simultaneous push+pop at count 3, 8 and 0.
        cycle(0, 0, 0, 1, "flush");
        for (int i = 0; i < 3; i++) cycle(1, 4'(i), 0, 0, "c3push");
        cycle(1, 4'h6, 1, 0, "c3both");
        chk("c3_diff_addr", 32'(obs_aw != obs_ar), 32'd1);
        cycle(0, 0, 0, 0, "idle");
        chk("c3_cnt", 32'(obs_cnt), 32'd3);
        for (int i = 0; i < 5; i++) cycle(1, 4'(i + 8), 0, 0, "c8push");
        cycle(1, 4'h1, 1, 0, "c8both");
        chk("c8_wr", 32'(obs_wr), 32'd0);
        chk("c8_rd", 32'(obs_rd), 32'd1);
        cycle(0, 0, 0, 0, "idle");
        chk("c8_cnt", 32'(obs_cnt), 32'd7);
        chk("c8_ovf", 32'(obs_ovf), 32'd1);
        cycle(0, 0, 0, 1, "flush");
        cycle(1, 4'h4, 1, 0, "c0both");
        cycle(0, 0, 0, 0, "idle");
        chk("c0_cnt", 32'(obs_cnt), 32'd1);
        chk("c0_unf", 32'(obs_unf), 32'd1);

        // Flush at count 5 with overflow set and a concurrent push.
        cycle(0, 0, 0, 1, "flush");
        for (int i = 0; i < 9; i++) cycle(1, 4'(i), 0, 0, "fpush");
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "fpop");
        cycle(1, 4'hC, 0, 1, "flush_push");
        chk("fl_pre_cnt", 32'(obs_cnt), 32'd5);
        chk("fl_pre_ovf", 32'(obs_ovf), 32'd1);
        chk("fl_wr", 32'(obs_wr), 32'd0);
        cycle(0, 0, 0, 0, "idle");
        chk("fl_cnt", 32'(obs_cnt), 32'd0);
        chk("fl_empty", 32'(obs_empty), 32'd1);
        chk("fl_ovf", 32'(obs_ovf), 32'd0);

        // Reset while a pop is pending: no pop_valid afterwards.
        cycle(1, 4'h2, 0, 0, "rpush");
        cycle(0, 0, 1, 0, "rpop");
        do_reset(1);
        cycle(0, 0, 0, 0, "idle");
        chk("rst_no_pv", 32'(obs_pv), 32'd0);

        // Randomized traffic with phase-varying bias to reach full and empty.
        for (int i = 0; i < 2000; i++) begin
            int pb;
            bit rp, rq, rf;
            pb = ((i / 150) % 2 == 0) ? 70 : 30;
            rp = ($urandom_range(0, 99) < pb);
            rq = ($urandom_range(0, 99) < (100 - pb));
            rf = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 499) == 0) do_reset(1);
            cycle(rp, 4'($urandom_range(0, 15)), rq, rf, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
